// File: rtl/ternary_mac_sequencer.sv
// Sequences one shared ternary MAC over a weight array: load a vector, then one dot-product row per result.
// Optional macro TERNARY_SEQ_SATURATE_EN clamps each result to the signed BIT_WIDTH range.
module ternary_mac_sequencer #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int BIT_WIDTH   = 8,
  parameter int ACC_W       = BIT_WIDTH + $clog2(MAX_IN_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [$clog2(MAX_IN_LEN)-1:0]  cfg_in_len_m1,
  input  logic [$clog2(MAX_OUT_LEN)-1:0] cfg_out_len_m1,
  input  logic                           vec_valid,
  output logic                           vec_ready,
  input  logic [BIT_WIDTH-1:0]           vec_data,
  output logic [$clog2(MAX_OUT_LEN)-1:0] w_row,
  output logic [$clog2(MAX_IN_LEN)-1:0]  w_col,
  input  logic [1:0]                     w_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_data,
  output logic [$clog2(MAX_OUT_LEN)-1:0] out_row,
  output logic                           busy,
  output logic                           done
);
  localparam int IW = $clog2(MAX_IN_LEN);
  localparam int OW = $clog2(MAX_OUT_LEN);

  typedef enum logic [1:0] {IDLE, LOAD_VEC, COMPUTE, EMIT} state_t;

  state_t                   state_reg;
  logic [IW-1:0]            in_idx_reg;
  logic [OW-1:0]            out_idx_reg;
  logic [IW-1:0]            in_len_m1_reg;
  logic [OW-1:0]            out_len_m1_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]         out_data_reg;
  logic [OW-1:0]            out_row_reg;
  logic                     vec_ready_reg;
  logic                     out_valid_reg;
  logic                     done_reg;

  logic [BIT_WIDTH-1:0]     vbuf [MAX_IN_LEN];
  logic [MAX_IN_LEN-1:0]    wr_sel;
  logic                     vec_wr;

  logic [BIT_WIDTH-1:0]     elem;
  logic signed [ACC_W-1:0]  elem_ext;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [ACC_W-1:0]  result_next;

  // abort wins over a simultaneous beat, so an aborted load never writes the buffer
  assign vec_wr = vec_ready_reg && vec_valid && !abort;

  for (genvar gi = 0; gi < MAX_IN_LEN; gi++) begin : g_wr_sel
    assign wr_sel[gi] = vec_wr && (in_idx_reg == IW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_IN_LEN; i++) vbuf[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_IN_LEN; i++) begin
        if (wr_sel[i]) vbuf[i] <= vec_data;
      end
    end
  end

  // 2'b10 is reserved and contributes nothing, same as 2'b00
  always_comb begin
    elem     = vbuf[in_idx_reg];
    elem_ext = {{(ACC_W-BIT_WIDTH){elem[BIT_WIDTH-1]}}, elem};
    case (w_data)
      2'b01:   prod = elem_ext;
      2'b11:   prod = -elem_ext;
      default: prod = '0;
    endcase
    sum_next = acc_reg + prod;
  end

`ifdef TERNARY_SEQ_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (BIT_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  always_comb begin
    if (sum_next > SAT_MAX)      result_next = SAT_MAX;
    else if (sum_next < SAT_MIN) result_next = SAT_MIN;
    else                         result_next = sum_next;
  end
`else
  assign result_next = sum_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      in_idx_reg     <= '0;
      out_idx_reg    <= '0;
      in_len_m1_reg  <= '0;
      out_len_m1_reg <= '0;
      acc_reg        <= '0;
      out_data_reg   <= '0;
      out_row_reg    <= '0;
      vec_ready_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg     <= IDLE;
        vec_ready_reg <= 1'b0;
        out_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              in_len_m1_reg  <= cfg_in_len_m1;
              out_len_m1_reg <= cfg_out_len_m1;
              in_idx_reg     <= '0;
              out_idx_reg    <= '0;
              vec_ready_reg  <= 1'b1;
              state_reg      <= LOAD_VEC;
            end
          end
          LOAD_VEC: begin
            if (vec_valid) begin
              if (in_idx_reg == in_len_m1_reg) begin
                in_idx_reg    <= '0;
                acc_reg       <= '0;
                vec_ready_reg <= 1'b0;
                state_reg     <= COMPUTE;
              end else begin
                in_idx_reg <= in_idx_reg + IW'(1);
              end
            end
          end
          COMPUTE: begin
            acc_reg <= sum_next;
            if (in_idx_reg == in_len_m1_reg) begin
              out_data_reg  <= result_next;
              out_row_reg   <= out_idx_reg;
              out_valid_reg <= 1'b1;
              state_reg     <= EMIT;
            end else begin
              in_idx_reg <= in_idx_reg + IW'(1);
            end
          end
          EMIT: begin
            if (out_ready) begin
              out_valid_reg <= 1'b0;
              if (out_idx_reg == out_len_m1_reg) begin
                done_reg  <= 1'b1;
                state_reg <= IDLE;
              end else begin
                out_idx_reg <= out_idx_reg + OW'(1);
                in_idx_reg  <= '0;
                acc_reg     <= '0;
                state_reg   <= COMPUTE;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign vec_ready = vec_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_row   = out_row_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE);
  assign w_row     = out_idx_reg;
  assign w_col     = in_idx_reg;
endmodule
